// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide unit.
//   op_e    : funct3 encodings of the eight M-extension operations
//   state_e : sequencing states of muldiv_unit
//   DIV_ZERO_Q, INT_MIN : special-case result constants
//   negate_if : two's complement negation when a condition holds
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  function automatic logic [31:0] negate_if(input logic [31:0] value, input logic neg);
    return neg ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the core and muldiv_unit.
//   start/op/src_a/src_b/rd_in : request (op is funct3, operands are RD1/RD2)
//   flush                      : abort the in-flight operation
//   busy                       : core must stall
//   done/result/rd_out         : one-cycle write-back strobe with data and rd
// master = core side, slave = execution unit side.
interface muldiv_unit_if #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 5
);

  logic                 start;
  logic [2:0]           op;
  logic [DATAWIDTH-1:0] src_a;
  logic [DATAWIDTH-1:0] src_b;
  logic [ADDRWIDTH-1:0] rd_in;
  logic                 flush;
  logic                 busy;
  logic                 done;
  logic [DATAWIDTH-1:0] result;
  logic [ADDRWIDTH-1:0] rd_out;

  modport master (
    output start, op, src_a, src_b, rd_in, flush,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, op, src_a, src_b, rd_in, flush,
    output busy, done, result, rd_out
  );

endinterface

// File: rtl/div_core.sv
// div_core: unsigned radix-2 restoring divider datapath.
//   clk, rst          : clock, synchronous active-high reset
//   load              : capture dividend/divisor magnitudes, clear remainder
//   step              : resolve one quotient bit (shift-subtract)
//   dividend, divisor : unsigned magnitudes, sampled on load
//   quo_next, rem_next: quotient/remainder after the step taken this cycle;
//                       the parent samples these on the final step so the
//                       last bit does not need an extra cycle.
module div_core #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [DATAWIDTH-1:0] dividend,
  input  logic [DATAWIDTH-1:0] divisor,
  output logic [DATAWIDTH-1:0] quo_next,
  output logic [DATAWIDTH-1:0] rem_next
);

  logic [DATAWIDTH-1:0] rem_q, rem_d;
  logic [DATAWIDTH-1:0] quo_q, quo_d;
  logic [DATAWIDTH-1:0] dvsr_q, dvsr_d;
  logic [DATAWIDTH:0]   partial;
  logic [DATAWIDTH:0]   diff;

  // The quotient register doubles as the dividend shift register: its MSB
  // moves into the partial remainder and the new quotient bit enters at LSB.
  // A clear borrow bit means the trial subtraction succeeded.
  always_comb begin
    partial  = {rem_q, quo_q[DATAWIDTH-1]};
    diff     = partial - {1'b0, dvsr_q};
    quo_next = {quo_q[DATAWIDTH-2:0], ~diff[DATAWIDTH]};
    rem_next = diff[DATAWIDTH] ? partial[DATAWIDTH-1:0] : diff[DATAWIDTH-1:0];

    rem_d  = rem_q;
    quo_d  = quo_q;
    dvsr_d = dvsr_q;
    if (load) begin
      rem_d  = '0;
      quo_d  = dividend;
      dvsr_d = divisor;
    end else if (step) begin
      rem_d = rem_next;
      quo_d = quo_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvsr_q <= dvsr_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide execution unit.
//   clk, rst : clock, synchronous active-high reset
//   bus      : muldiv_unit_if.slave (start/op/src_a/src_b/rd_in/flush in,
//              busy/done/result/rd_out out)
// Multiplies take one MUL cycle; divides take 32 DIV cycles; divide by zero
// and signed overflow complete directly from the accepting cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 5
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);

  state_e               state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  op_e                  op_q, op_d;
  logic [DATAWIDTH-1:0] a_q, a_d;
  logic [DATAWIDTH-1:0] b_q, b_d;
  logic [ADDRWIDTH-1:0] rd_q, rd_d;
  logic [DATAWIDTH-1:0] result_q, result_d;
  logic [ADDRWIDTH-1:0] rd_out_q, rd_out_d;
  logic                 done_q, done_d;

  logic                 div_load, div_step;
  logic [DATAWIDTH-1:0] dividend_mag, divisor_mag;
  logic [DATAWIDTH-1:0] quo_next, rem_next;

  logic                 req_is_mul, req_signed, req_is_rem;
  logic                 req_div_zero, req_overflow;
  logic [DATAWIDTH-1:0] special_res;

  logic                 a_sgn, b_sgn;
  logic [2*DATAWIDTH-1:0] a_ext, b_ext, product;
  logic [DATAWIDTH-1:0] mul_res;
  logic [DATAWIDTH-1:0] div_res;

  // Decode of the incoming request; used only in the accepting cycle.
  // funct3[2] selects divide, funct3[0] unsigned, funct3[1] remainder.
  always_comb begin
    req_is_mul   = ~bus.op[2];
    req_signed   = ~bus.op[0];
    req_is_rem   = bus.op[1];
    req_div_zero = (bus.src_b == '0);
    req_overflow = req_signed && (bus.src_a == INT_MIN) && (bus.src_b == DIV_ZERO_Q);
    if (req_div_zero) begin
      special_res = req_is_rem ? bus.src_a : DIV_ZERO_Q;
    end else begin
      special_res = req_is_rem ? '0 : INT_MIN;
    end
    dividend_mag = negate_if(bus.src_a, req_signed & bus.src_a[DATAWIDTH-1]);
    divisor_mag  = negate_if(bus.src_b, req_signed & bus.src_b[DATAWIDTH-1]);
  end

  // The low half of a 64x64 product of the sign/zero-extended operands is
  // the exact 64-bit result for every signedness combination.
  always_comb begin
    a_sgn   = (op_q == OP_MULH) || (op_q == OP_MULHSU);
    b_sgn   = (op_q == OP_MULH);
    a_ext   = {{DATAWIDTH{a_sgn & a_q[DATAWIDTH-1]}}, a_q};
    b_ext   = {{DATAWIDTH{b_sgn & b_q[DATAWIDTH-1]}}, b_q};
    product = a_ext * b_ext;
    mul_res = (op_q == OP_MUL) ? product[DATAWIDTH-1:0] : product[2*DATAWIDTH-1:DATAWIDTH];
  end

  // Sign fix-up applied to the final divider step: the quotient is negative
  // when operand signs differ, the remainder follows the dividend.
  always_comb begin
    if (op_q[1]) begin
      div_res = negate_if(rem_next, ~op_q[0] & a_q[DATAWIDTH-1]);
    end else begin
      div_res = negate_if(quo_next,
                          ~op_q[0] & (a_q[DATAWIDTH-1] ^ b_q[DATAWIDTH-1]));
    end
  end

  div_core #(
    .DATAWIDTH(DATAWIDTH)
  ) u_div_core (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (dividend_mag),
    .divisor  (divisor_mag),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );

  // Next-state logic. Results are written only on completion, so a flush
  // leaves result/rd_out untouched. Flush dominates a same-cycle start.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rd_d     = rd_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    done_d   = 1'b0;
    div_load = 1'b0;
    div_step = 1'b0;

    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        MUL: begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = mul_res;
          rd_out_d = rd_q;
        end
        DIV: begin
          div_step = 1'b1;
          cnt_d    = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = div_res;
            rd_out_d = rd_q;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request.
          state_d = IDLE;
          if (bus.start) begin
            op_d = op_e'(bus.op);
            a_d  = bus.src_a;
            b_d  = bus.src_b;
            rd_d = bus.rd_in;
            if (req_is_mul) begin
              state_d = MUL;
            end else if (req_div_zero || req_overflow) begin
              state_d  = DONE;
              done_d   = 1'b1;
              result_d = special_res;
              rd_out_d = bus.rd_in;
            end else begin
              state_d  = DIV;
              cnt_d    = '0;
              div_load = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      result_q <= '0;
      rd_out_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = (state_q == MUL) || (state_q == DIV);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit. Expected results and
// latencies come from an arithmetic reference model of the RV32M rules.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] last_res;
  logic [4:0]  last_rd;

  muldiv_unit_if #(.DATAWIDTH(32), .ADDRWIDTH(5)) bus ();

  muldiv_unit #(
    .DATAWIDTH(32),
    .ADDRWIDTH(5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference result from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    int ia, ib;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Clock edges from the accepting edge until done is visible.
  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] == 1'b0) return 1;
    if (b == 0) return 0;
    if (op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 32;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Presents a request for one accepting edge, then scrambles the operands.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    bus.rd_in = rd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 3'($urandom_range(0, 7));
    bus.src_a = $urandom;
    bus.src_b = $urandom;
    bus.rd_in = 5'($urandom_range(0, 31));
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    logic [31:0] exp_res;
    int          exp_lat;
    int          n;
    logic        busy_ok;
    exp_res = ref_result(op, a, b);
    exp_lat = ref_latency(op, a, b);
    applyStimulus(op, a, b, rd);
    n       = 0;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, " latency"}, 32'(n), 32'(exp_lat));
    checkOutput({tag, " busy while running"}, {31'b0, busy_ok}, 32'd1);
    checkOutput({tag, " busy at done"}, {31'b0, bus.busy}, 32'd0);
    checkOutput({tag, " result"}, bus.result, exp_res);
    checkOutput({tag, " rd_out"}, {27'b0, bus.rd_out}, {27'b0, rd});
    last_res = exp_res;
    last_rd  = rd;
    @(posedge clk);
    #1;
    checkOutput({tag, " single done"}, {31'b0, bus.done}, 32'd0);
  endtask

  // Counts done pulses over a window where none should occur.
  task automatic expectQuiet(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.done === 1'b1) pulses++;
      @(posedge clk);
      #1;
    end
    checkOutput({tag, " no done"}, 32'(pulses), 32'd0);
  endtask

  initial begin
    logic [31:0] exp1, exp2;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          n;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 3'd0;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.rd_in = '0;
    last_res  = '0;
    last_rd   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("reset done", {31'b0, bus.done}, 32'd0);
    checkOutput("reset result", bus.result, 32'd0);
    checkOutput("reset rd_out", {27'b0, bus.rd_out}, 32'd0);

    $display("[TB] directed multiplies");
    runOp("MUL 7*-3", OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5);
    checkOutput("MUL 7*-3 literal", last_res, 32'hFFFF_FFEB);
    runOp("MULH -1*-1", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
    checkOutput("MULH literal", last_res, 32'h0000_0000);
    runOp("MULHSU -1*-1", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    checkOutput("MULHSU literal", last_res, 32'hFFFF_FFFF);
    runOp("MULHU -1*-1", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    checkOutput("MULHU literal", last_res, 32'hFFFF_FFFE);

    $display("[TB] directed divides");
    runOp("DIV -20/3", OP_DIV, 32'hFFFF_FFEC, 32'd3, 5'd6);
    checkOutput("DIV literal", last_res, 32'hFFFF_FFFA);
    runOp("REM -20/3", OP_REM, 32'hFFFF_FFEC, 32'd3, 5'd7);
    checkOutput("REM literal", last_res, 32'hFFFF_FFFE);
    runOp("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 5'd8);
    checkOutput("DIVU literal", last_res, 32'd14);
    runOp("REMU 100/7", OP_REMU, 32'd100, 32'd7, 5'd9);
    checkOutput("REMU literal", last_res, 32'd2);

    $display("[TB] special cases");
    runOp("DIVU x/0", OP_DIVU, 32'hDEAD_BEEF, 32'd0, 5'd10);
    runOp("REM 0x1234/0", OP_REM, 32'h0000_1234, 32'd0, 5'd11);
    runOp("DIV overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    runOp("REM overflow", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);

    $display("[TB] back-to-back issue");
    exp1 = ref_result(OP_DIV, 32'hFFFF_FF9C, 32'd7);
    exp2 = ref_result(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
    applyStimulus(OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd13);
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.src_a = 32'd5;
    bus.src_b = 32'd6;
    bus.rd_in = 5'd20;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput("ignored start busy", {31'b0, bus.busy}, 32'd1);
    n = 4;
    while (bus.done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("b2b first latency", 32'(n), 32'd32);
    checkOutput("b2b first result", bus.result, exp1);
    checkOutput("b2b first rd_out", {27'b0, bus.rd_out}, 32'd13);
    bus.start = 1'b1;
    bus.op    = OP_MULHU;
    bus.src_a = 32'h1234_5678;
    bus.src_b = 32'h9ABC_DEF0;
    bus.rd_in = 5'd14;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput("b2b gap done", {31'b0, bus.done}, 32'd0);
    checkOutput("b2b gap busy", {31'b0, bus.busy}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("b2b second done", {31'b0, bus.done}, 32'd1);
    checkOutput("b2b second result", bus.result, exp2);
    checkOutput("b2b second rd_out", {27'b0, bus.rd_out}, 32'd14);
    last_res = exp2;
    last_rd  = 5'd14;
    @(posedge clk);
    #1;
    checkOutput("b2b second single", {31'b0, bus.done}, 32'd0);

    $display("[TB] flush mid-divide with colliding start");
    applyStimulus(OP_DIVU, 32'd1000, 32'd3, 5'd15);
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.src_a = 32'd2;
    bus.src_b = 32'd2;
    bus.rd_in = 5'd16;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    checkOutput("flush busy", {31'b0, bus.busy}, 32'd0);
    expectQuiet("flush", 40);
    checkOutput("flush result kept", bus.result, last_res);
    checkOutput("flush rd_out kept", {27'b0, bus.rd_out}, {27'b0, last_rd});

    $display("[TB] reset mid-divide");
    applyStimulus(OP_DIV, 32'd5000, 32'hFFFF_FFF9, 5'd17);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("rst result", bus.result, 32'd0);
    checkOutput("rst rd_out", {27'b0, bus.rd_out}, 32'd0);
    expectQuiet("rst", 40);
    runOp("DIVU 9/2 after rst", OP_DIVU, 32'd9, 32'd2, 5'd18);
    checkOutput("DIVU 9/2 literal", last_res, 32'd4);

    $display("[TB] randomized operations");
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: ;
      endcase
      runOp($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, 5'($urandom_range(0, 31)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
